// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, RAM handshake state and the memory arbiter FSM state.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } arbstate_t;

endpackage

// File: rtl/memory_arbiter_if.sv
// Bundle of the fetch port, data port and RAM-side signals around memory_arbiter.
interface memory_arbiter_if;
    import cpu_types_pkg::*;

    logic      iREN;
    word_t     iaddr;
    logic      iwait;
    word_t     iload;
    logic      dREN;
    logic      dWEN;
    word_t     daddr;
    word_t     dstore;
    logic      dwait;
    word_t     dload;
    logic      ramREN;
    logic      ramWEN;
    word_t     ramaddr;
    word_t     ramstore;
    word_t     ramload;
    ramstate_t ramstate;
    logic      mem_err;

    modport ma (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
    );

    modport tb (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore, mem_err
    );

endinterface

// File: rtl/memory_arbiter.sv
// Three-process FSM sharing the single-ported RAM between instruction fetch and data access.
// Build macro MEM_ARB_RR_EN: alternate the winner of simultaneous requests (default: data wins).
module memory_arbiter
    import cpu_types_pkg::*;
(
    input  logic         CLK,
    input  logic         nRST,
    memory_arbiter_if.ma mif
);

    arbstate_t state_q;
    arbstate_t state_d;
    logic      dreq_s;
    logic      ram_access_s;
    logic      i_done_s;
    logic      d_done_s;
    logic      d_first_s;

    assign dreq_s       = mif.dREN | mif.dWEN;
    assign ram_access_s = (mif.ramstate == ACCESS);
    // A completion needs the request still live; a dropped request never gets a wait-low.
    assign i_done_s     = (state_q == IGNT) & mif.iREN & ram_access_s;
    assign d_done_s     = (state_q == DGNT) & dreq_s & ram_access_s;

`ifdef MEM_ARB_RR_EN
    logic last_d_q;
    logic last_d_d;

    // Remember which port completed most recently.
    always_comb begin
        last_d_d = last_d_q;
        if (d_done_s) begin
            last_d_d = 1'b1;
        end else if (i_done_s) begin
            last_d_d = 1'b0;
        end else begin
            last_d_d = last_d_q;
        end
    end

    // Round-robin history register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end

    assign d_first_s = ~last_d_q;
`else
    assign d_first_s = 1'b1;
`endif

    // FSM state register.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; the port just served is left out of the hand-over decision.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (dreq_s && mif.iREN) begin
                    state_d = d_first_s ? DGNT : IGNT;
                end else if (dreq_s) begin
                    state_d = DGNT;
                end else if (mif.iREN) begin
                    state_d = IGNT;
                end else begin
                    state_d = IDLE;
                end
            end
            IGNT: begin
                if (!mif.iREN) begin
                    state_d = IDLE;
                end else if (ram_access_s) begin
                    state_d = dreq_s ? DGNT : IDLE;
                end else begin
                    state_d = IGNT;
                end
            end
            DGNT: begin
                if (!dreq_s) begin
                    state_d = IDLE;
                end else if (ram_access_s) begin
                    state_d = mif.iREN ? IGNT : IDLE;
                end else begin
                    state_d = DGNT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output mux: RAM enables follow the live request of the granted port only.
    always_comb begin
        mif.iwait    = 1'b1;
        mif.iload    = 32'h0000_0000;
        mif.dwait    = 1'b1;
        mif.dload    = 32'h0000_0000;
        mif.ramREN   = 1'b0;
        mif.ramWEN   = 1'b0;
        mif.ramaddr  = 32'h0000_0000;
        mif.ramstore = 32'h0000_0000;
        mif.mem_err  = 1'b0;
        case (state_q)
            IDLE: begin
                mif.ramREN = 1'b0;
            end
            IGNT: begin
                mif.ramREN  = mif.iREN;
                mif.ramaddr = mif.iaddr;
                mif.mem_err = (mif.ramstate == ERROR);
                if (i_done_s) begin
                    mif.iwait = 1'b0;
                    mif.iload = mif.ramload;
                end else begin
                    mif.iwait = 1'b1;
                    mif.iload = 32'h0000_0000;
                end
            end
            DGNT: begin
                mif.ramREN   = mif.dREN;
                mif.ramWEN   = mif.dWEN;
                mif.ramaddr  = mif.daddr;
                mif.ramstore = mif.dstore;
                mif.mem_err  = (mif.ramstate == ERROR);
                if (d_done_s) begin
                    mif.dwait = 1'b0;
                    mif.dload = mif.ramload;
                end else begin
                    mif.dwait = 1'b1;
                    mif.dload = 32'h0000_0000;
                end
            end
            default: begin
                mif.ramREN = 1'b0;
            end
        endcase
    end

endmodule

// File: doc/memory_arbiter.md
# memory_arbiter

Sequential arbiter that shares the single-ported RAM between the instruction-fetch port and the data-memory port of the CPU. It accepts held-level requests from both ports, grants one at a time through a small FSM, and forwards the grant to the RAM. It returns a per-port wait signal that drops for exactly one cycle when the RAM completes the access. It sits between the request unit and the RAM, below the control unit's iREN/dREN/dWEN outputs.

## Interface
- No parameters; widths come from `cpu_types_pkg` (`word_t` is 32 bits).
- `CLK` in 1: system clock, rising edge.
- `nRST` in 1: asynchronous, active-low reset.
- `iREN` in 1: instruction read request, held until `iwait` is low.
- `iaddr` in 32: instruction address.
- `iwait` out 1: 1 = instruction access not complete.
- `iload` out 32: instruction data, valid when `iwait` = 0.
- `dREN` / `dWEN` in 1 each: data read/write request, held until `dwait` is low. Never both set.
- `daddr` / `dstore` in 32: data address and write data.
- `dwait` out 1: 1 = data access not complete.
- `dload` out 32: read data, valid when `dwait` = 0.
- `ramREN` / `ramWEN` out 1: RAM enables.
- `ramaddr` / `ramstore` out 32: RAM address and write data.
- `ramload` in 32: RAM read data.
- `ramstate` in `ramstate_t`: FREE, BUSY, ACCESS, ERROR.
- `mem_err` out 1: one-cycle pulse when ERROR is seen during a grant.

## Operation
- FSM states: IDLE, IGNT, DGNT. Reset state is IDLE.
- Define `dreq` = `dREN` | `dWEN`.
- **IDLE:**
  - Only `dreq` set → DGNT.
  - Only `iREN` set → IGNT.
  - Both set → the priority rule under Configuration.
  - Neither set → stay in IDLE.
- **IGNT:**
  - `ramREN` = 1, `ramaddr` = `iaddr`.
  - On `ramstate` = ACCESS: `iwait` = 0 and `iload` = `ramload` this cycle.
  - Next state is DGNT if `dreq`, else IDLE. The just-served instruction request is excluded from this decision.
- **DGNT:**
  - `ramREN` = `dREN`, `ramWEN` = `dWEN`, `ramaddr` = `daddr`, `ramstore` = `dstore`.
  - On ACCESS: `dwait` = 0 and `dload` = `ramload`.
  - Next state is IGNT if `iREN`, else IDLE.
- **FREE/BUSY during a grant:** hold the grant; the wait signal stays 1.
- **ERROR during a grant:** `mem_err` = 1 for that cycle, the grant is held, and the access retries until ACCESS.
- **Request dropped while granted** (illegal, but must be tolerated): RAM enables follow the live inputs and go 0. On the next edge the FSM returns to IDLE without asserting a wait-low.
- **Ungranted port:** wait = 1, load = 0.
- **In IDLE:** `ramREN` = `ramWEN` = 0, `ramaddr` = 0, `ramstore` = 0.
- All outputs are combinational from the state register and the live inputs. There are no registered data paths.

## Timing
- **Reset:** FSM to IDLE asynchronously. While `nRST` = 0: `iwait` = `dwait` = 1, `ramREN` = `ramWEN` = 0, `mem_err` = 0, `iload` = `dload` = 0. Reset mid-grant abandons the access with no completion pulse.
- **Latency:**
  - Request seen in IDLE at cycle 0 → RAM enables asserted from cycle 1.
  - Completion occurs in the first cycle with ACCESS. With a 0-wait RAM (ACCESS immediately), wait is low at cycle 1.
- **Completion pulse:** wait-low lasts exactly one cycle per access.
- **Back-to-back requests from the same port:** one IDLE bubble between them.
- **Alternating ports:** no bubble; the next grant takes effect on the edge after ACCESS.

## Configuration
- **`MEM_ARB_RR_EN` undefined:** fixed priority. Data wins a simultaneous request in IDLE. Instruction fetch can starve under continuous data traffic.
- **`MEM_ARB_RR_EN` defined:**
  - A `last_d` flag, reset to 0, is set when a DGNT completes and cleared when an IGNT completes.
  - On a simultaneous request in IDLE, DGNT is granted if `last_d` = 0, else IGNT.
- Transitions from IGNT and DGNT are identical in both builds.

## Structure
- Use `cpu_types_pkg` for `word_t` and `ramstate_t`.
- Add `arbstate_t` (enum IDLE, IGNT, DGNT) to `cpu_types_pkg`.
- Single module with no sub-module. The FSM and output mux are one file.
- Add `memory_arbiter_if` with modports `ma` and `tb`.

## Test plan
- **Reset:** assert `nRST` = 0 mid-DGNT with `ramstate` = BUSY → `ramWEN` = 0 and `dwait` = 1 immediately; IDLE after release.
- **Single instruction fetch:** `iREN` = 1, `iaddr` = 0x0000_0040, RAM returns ACCESS after 2 BUSY cycles with `ramload` = 0x2008_0001 → `iwait` low only at cycle 3 with `iload` = 0x2008_0001.
- **Simultaneous requests, fixed build:** `dWEN` at `daddr` = 0x100 with `dstore` = 0xDEAD_BEEF, plus `iREN` at 0x0 → write granted first (`ramstore` = 0xDEAD_BEEF), IGNT directly afterwards with no bubble.
- **`MEM_ARB_RR_EN`:** after one completed DGNT, a simultaneous request → IGNT granted first.
- **ERROR:** ramstate sequence ERROR, ERROR, ACCESS during a DGNT read → `mem_err` pulses twice, `dwait` low once, `dload` = `ramload`.
- **Back-to-back same-port reads:** two consecutive `dREN` reads with a 0-wait RAM → completions at cycles 1 and 3, IDLE at cycle 2.
